// File: rtl/line_transfer_engine_if.sv
// Bus bundles around the line transfer engine: the controller-side line port
// and the memory-side narrow beat port.
interface line_req_if #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int CACHE_LINE_SIZE = 128
);
  logic                       req_valid;
  logic                       req_ready;
  logic                       req_write;
  logic [ADDRESS_WIDTH-1:0]   req_address;
  logic [CACHE_LINE_SIZE-1:0] req_line;
  logic                       resp_valid;
  logic                       resp_write;
  logic [CACHE_LINE_SIZE-1:0] resp_line;
  logic                       busy;

  modport master (
    output req_valid, req_write, req_address, req_line,
    input  req_ready, resp_valid, resp_write, resp_line, busy
  );
  modport slave (
    input  req_valid, req_write, req_address, req_line,
    output req_ready, resp_valid, resp_write, resp_line, busy
  );
endinterface

interface mem_beat_if #(
  parameter int ADDRESS_WIDTH  = 32,
  parameter int MEM_DATA_WIDTH = 32
);
  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic                      mem_req_write;
  logic [ADDRESS_WIDTH-1:0]  mem_req_address;
  logic [MEM_DATA_WIDTH-1:0] mem_req_data;
  logic                      mem_rsp_valid;
  logic [MEM_DATA_WIDTH-1:0] mem_rsp_data;

  modport master (
    output mem_req_valid, mem_req_write, mem_req_address, mem_req_data,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
  modport slave (
    input  mem_req_valid, mem_req_write, mem_req_address, mem_req_data,
    output mem_req_ready, mem_rsp_valid, mem_rsp_data
  );
endinterface

// File: rtl/line_transfer_engine.sv
// Splits a whole-line write-back or fill into narrow memory beats and
// reassembles fill beats into a full line for the cache controller.
//
// state | meaning
// IDLE  | ready for a line transaction
// WB    | issuing write beats from the latched victim line
// FILL  | issuing read beats and collecting in-order responses
// DONE  | one-cycle completion pulse on resp_valid
module line_transfer_engine #(
  parameter int ADDRESS_WIDTH   = 32,
  parameter int CACHE_LINE_SIZE = 128,
  parameter int MEM_DATA_WIDTH  = 32
) (
  input  logic       clk,
  input  logic       rst,
  line_req_if.slave  ctrl,
  mem_beat_if.master mem
);
  localparam int BEATS       = CACHE_LINE_SIZE / MEM_DATA_WIDTH;
  localparam int BEAT_BYTES  = MEM_DATA_WIDTH / 8;
  localparam int OFFSET_BITS = $clog2(CACHE_LINE_SIZE / 8);
  localparam int CW          = $clog2(BEATS + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam logic [CW-1:0] ALL_BEATS = CW'(BEATS);
  localparam logic [ADDRESS_WIDTH-1:0] OFFSET_MASK =
    ADDRESS_WIDTH'((64'd1 << OFFSET_BITS) - 64'd1);

  typedef enum logic [1:0] {IDLE = 2'd0, WB = 2'd1, FILL = 2'd2, DONE = 2'd3} state_t;
  state_t state, next_state;

  logic [ADDRESS_WIDTH-1:0]   base_q;
  logic                       wr_q;
  logic [CACHE_LINE_SIZE-1:0] line_q;
  logic [CW-1:0]              tx, rx, tx_next, rx_next;
  logic                       accept, mem_acc, rsp_acc, issue_next;
  logic                       req_valid_q, req_write_q;
  logic [ADDRESS_WIDTH-1:0]   addr_q;
  logic [MEM_DATA_WIDTH-1:0]  data_q, beat_data;
  logic [CACHE_LINE_SIZE-1:0] resp_line_q;

  assign accept  = ctrl.req_valid && (state == IDLE);
  assign mem_acc = req_valid_q && mem.mem_req_ready;
  assign rsp_acc = (state == FILL) && mem.mem_rsp_valid && (rx != ALL_BEATS);
  assign tx_next = tx + CW'(mem_acc);
  assign rx_next = rx + CW'(rsp_acc);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = ctrl.req_write ? WB : FILL;
      WB:      if (mem_acc && (tx == LAST_BEAT)) next_state = DONE;
      FILL:    if ((tx == ALL_BEATS) && (rx_next == ALL_BEATS)) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Beat request registers are loaded from the post-acceptance counter so the
  // next beat is presented the cycle after the current one is taken.
  assign issue_next = ((state == WB) && (next_state == WB)) ||
                      ((state == FILL) && (tx_next < ALL_BEATS));

  always_comb begin
    beat_data = '0;
    for (int i = 0; i < BEATS; i++)
      if (tx_next == CW'(i)) beat_data = line_q[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base_q      <= '0;
      wr_q        <= 1'b0;
      line_q      <= '0;
      tx          <= '0;
      rx          <= '0;
      req_valid_q <= 1'b0;
      req_write_q <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      resp_line_q <= '0;
    end else begin
      if (accept) begin
        base_q <= ctrl.req_address & ~OFFSET_MASK;
        wr_q   <= ctrl.req_write;
        line_q <= ctrl.req_line;
        tx     <= '0;
        rx     <= '0;
      end else begin
        tx <= tx_next;
        rx <= rx_next;
      end
      req_valid_q <= issue_next;
      req_write_q <= issue_next && (state == WB);
      if (issue_next) begin
        addr_q <= base_q + ADDRESS_WIDTH'(tx_next) * ADDRESS_WIDTH'(BEAT_BYTES);
        data_q <= (state == WB) ? beat_data : '0;
      end
      if (rsp_acc)
        for (int i = 0; i < BEATS; i++)
          if (rx == CW'(i)) resp_line_q[i*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] <= mem.mem_rsp_data;
    end
  end

  assign ctrl.req_ready  = (state == IDLE);
  assign ctrl.busy       = (state != IDLE);
  assign ctrl.resp_valid = (state == DONE);
  assign ctrl.resp_write = (state == DONE) && wr_q;
  assign ctrl.resp_line  = resp_line_q;

  assign mem.mem_req_valid   = req_valid_q;
  assign mem.mem_req_write   = req_write_q;
  assign mem.mem_req_address = addr_q;
  assign mem.mem_req_data    = data_q;
endmodule
